// File: rtl/three_phase_spwm_if.sv
// three_phase_spwm_if: enable, sine samples in; gate drives, valley strobe, debug carrier out.
// Rev 1.0
`default_nettype none

interface three_phase_spwm_if;
    logic        en;
    logic [15:0] mod_a;
    logic [15:0] mod_b;
    logic [15:0] mod_c;
    logic [2:0]  gate_hi;
    logic [2:0]  gate_lo;
    logic        valley;
    logic [15:0] carrier;

    modport master (
        output en, mod_a, mod_b, mod_c,
        input  gate_hi, gate_lo, valley, carrier
    );

    modport slave (
        input  en, mod_a, mod_b, mod_c,
        output gate_hi, gate_lo, valley, carrier
    );
endinterface

`default_nettype wire

// File: rtl/three_phase_spwm.sv
// three_phase_spwm: triangle-carrier regular-sampled SPWM, three phases, optional dead-time
// FSMs selected by macro SPWM_DEADTIME_EN.  Rev 1.0
`default_nettype none

module three_phase_spwm #(
    parameter int         CARRIER_MAX = 1249,
    parameter logic [7:0] DEAD_CYCLES = 8'd8
) (
    input  logic              clk,
    input  logic              rst,
    three_phase_spwm_if.slave bus
);
    localparam logic [15:0] C_PEAK  = 16'(CARRIER_MAX);
    localparam logic [31:0] C_SCALE = 32'(CARRIER_MAX + 1);

    logic              w_run;
    logic              w_valley;
    logic [15:0]       carrier_q, carrier_d;
    logic              dir_up_q, dir_up_d;
    logic              valley_q;
    logic [2:0][15:0]  w_mod;
    logic [2:0][15:0]  mod_lat_q;
    logic [2:0][15:0]  cmp_q, cmp_d;
    logic [2:0]        pwm_q;
    logic [2:0]        pwm_prev_q;
    logic [2:0]        w_gate_hi;
    logic [2:0]        w_gate_lo;

    assign w_run    = bus.en & ~rst;
    assign w_mod    = {bus.mod_c, bus.mod_b, bus.mod_a};
    assign w_valley = w_run & (carrier_q == 16'd0) & dir_up_q;

    // Direction flips as the count lands on an endpoint, so each endpoint lasts one cycle.
    always_comb begin
        carrier_d = carrier_q;
        dir_up_d  = dir_up_q;
        if (!bus.en) begin
            carrier_d = 16'd0;
            dir_up_d  = 1'b1;
        end else if (dir_up_q) begin
            carrier_d = carrier_q + 16'd1;
            if (carrier_d == C_PEAK) dir_up_d = 1'b0;
        end else begin
            carrier_d = carrier_q - 16'd1;
            if (carrier_d == 16'd0) dir_up_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmp_d[i] = 16'(({16'd0, mod_lat_q[i]} * C_SCALE) >> 16);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q  <= 16'd0;
            dir_up_q   <= 1'b1;
            valley_q   <= 1'b0;
            mod_lat_q  <= {3{16'h8000}};
            cmp_q      <= '0;
            pwm_q      <= 3'b000;
            pwm_prev_q <= 3'b000;
        end else begin
            carrier_q  <= carrier_d;
            dir_up_q   <= dir_up_d;
            valley_q   <= w_valley;
            pwm_prev_q <= pwm_q;
            if (w_valley) mod_lat_q <= w_mod;
            if (valley_q) cmp_q <= cmp_d;
            for (int i = 0; i < 3; i++) begin
                pwm_q[i] <= (cmp_q[i] > carrier_q);
            end
        end
    end

`ifdef SPWM_DEADTIME_EN
    typedef enum logic [1:0] {
        LO_ON = 2'd0,
        DEAD  = 2'd1,
        HI_ON = 2'd2
    } dt_state_e;

    for (genvar p = 0; p < 3; p++) begin : g_phase
        dt_state_e  state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       w_edge;

        assign w_edge = pwm_q[p] ^ pwm_prev_q[p];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= DEAD;
                cnt_q   <= DEAD_CYCLES;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Any edge (including one inside DEAD) restarts the full dead interval.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!bus.en || w_edge) begin
                state_d = DEAD;
                cnt_d   = DEAD_CYCLES;
            end else if (state_q == DEAD) begin
                if (cnt_q == 8'd0) begin
                    state_d = pwm_q[p] ? HI_ON : LO_ON;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        end

        assign w_gate_hi[p] = w_run & (state_q == HI_ON);
        assign w_gate_lo[p] = w_run & (state_q == LO_ON);
    end
`else
    logic w_unused;

    assign w_unused  = ^{DEAD_CYCLES, pwm_prev_q};
    assign w_gate_hi = {3{w_run}} & pwm_q;
    assign w_gate_lo = {3{w_run}} & ~pwm_q;
`endif

    assign bus.gate_hi = w_gate_hi;
    assign bus.gate_lo = w_gate_lo;
    assign bus.valley  = w_valley;
    assign bus.carrier = carrier_q;

endmodule

`default_nettype wire

// File: tb/tb_three_phase_spwm.sv
// tb_three_phase_spwm: behavioural reference model with per-cycle comparison plus
// hand-computed period counts for three_phase_spwm.
`default_nettype none

module tb_three_phase_spwm;
    localparam int CMAX = 1249;
    localparam int DEAD = 8;
    localparam int PER  = 2 * CMAX;

`ifdef SPWM_DEADTIME_EN
    localparam int EXP_HI0   = 1240;
    localparam int EXP_BZ0   = 2 * (DEAD + 1);
    localparam int EXP_BZRUN = DEAD + 1;
    localparam int EXP_LO2   = 0;
`else
    localparam int EXP_HI0   = 1249;
    localparam int EXP_BZ0   = 0;
    localparam int EXP_BZRUN = 0;
    localparam int EXP_LO2   = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    three_phase_spwm_if bus();

    three_phase_spwm #(
        .CARRIER_MAX (CMAX),
        .DEAD_CYCLES (8'(DEAD))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    // k: consecutive running cycles before the current one (mod period) -> carrier phase.
    int          k = 0;
    longint      cyc = 0;
    logic [15:0] m_cmp [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] s_val [3];
    bit          s_vld = 1'b0;
    longint      s_at  = 0;
    bit          ph [3][DEAD+3];
    bit          rh [DEAD+2];
    logic        run, ev, all1, all0, allrun;
    logic [15:0] mods [3];
    int          mc;
    logic [2:0]  ehi, elo;
    bit          pnext [3];

    function automatic int tri_val(input int m);
        return (m <= CMAX) ? m : PER - m;
    endfunction

    function automatic logic [15:0] duty(input logic [15:0] m);
        longint v;
        v = longint'(m) * longint'(CMAX + 1) / 65536;
        return 16'(v);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) for (int i = 0; i < DEAD + 3; i++) ph[p][i] = 1'b0;
        for (int i = 0; i < DEAD + 2; i++) rh[i] = 1'b0;
    end

    always @(negedge clk) begin
        run     = bus.en & ~rst;
        mods[0] = bus.mod_a;
        mods[1] = bus.mod_b;
        mods[2] = bus.mod_c;
        mc      = tri_val(k);
        ev      = run && (k == 0);
        allrun  = run;
        for (int i = 1; i <= DEAD + 1; i++) allrun = allrun & rh[i];
        for (int p = 0; p < 3; p++) begin
`ifdef SPWM_DEADTIME_EN
            // Gate on only after DEAD+2 settled pwm cycles and DEAD+1 prior running cycles.
            all1 = 1'b1;
            all0 = 1'b1;
            for (int i = 1; i <= DEAD + 2; i++) begin
                all1 = all1 & ph[p][i];
                all0 = all0 & ~ph[p][i];
            end
            ehi[p] = allrun & all1;
            elo[p] = allrun & all0;
`else
            ehi[p] = run & ph[p][0];
            elo[p] = run & ~ph[p][0];
`endif
        end

        if (chk_en) begin
            n_cmp = n_cmp + 1;
            if ({bus.carrier, bus.valley, bus.gate_hi, bus.gate_lo} !== {16'(mc), ev, ehi, elo}) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle %0d outputs: carrier=%0d valley=%b hi=%b lo=%b, expected carrier=%0d valley=%b hi=%b lo=%b",
                         cyc, bus.carrier, bus.valley, bus.gate_hi, bus.gate_lo, mc, ev, ehi, elo);
            end
            n_cmp = n_cmp + 1;
            if ((bus.gate_hi & bus.gate_lo) !== 3'b000) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle %0d overlap: hi&lo=%b, expected 000", cyc, bus.gate_hi & bus.gate_lo);
            end
        end

        // advance the model to the next cycle
        for (int p = 0; p < 3; p++) pnext[p] = rst ? 1'b0 : (m_cmp[p] > 16'(mc));
        for (int p = 0; p < 3; p++) begin
            for (int i = DEAD + 2; i >= 1; i--) ph[p][i] = rst ? 1'b0 : ph[p][i-1];
            ph[p][0] = pnext[p];
        end
        for (int i = DEAD + 1; i >= 2; i--) rh[i] = rh[i-1];
        rh[1] = run;
        if (rst) begin
            for (int p = 0; p < 3; p++) m_cmp[p] = 16'd0;
            s_vld = 1'b0;
        end else if (s_vld && s_at == cyc + 1) begin
            for (int p = 0; p < 3; p++) m_cmp[p] = s_val[p];
            s_vld = 1'b0;
        end
        if (ev) begin
            s_vld = 1'b1;
            s_at  = cyc + 2;
            for (int p = 0; p < 3; p++) s_val[p] = duty(mods[p]);
        end
        k   = run ? (k + 1) % PER : 0;
        cyc = cyc + 1;
    end

    // ---------------- directed stimulus ----------------
    int len, maxc, hi0, bz0, bzrun, hi1, lo2;

    task automatic measure_period();
        int cur;
        len = 0; maxc = 0; hi0 = 0; bz0 = 0; bzrun = 0; hi1 = 0; lo2 = 0; cur = 0;
        do begin
            if (int'(bus.carrier) > maxc) maxc = int'(bus.carrier);
            hi0 += int'(bus.gate_hi[0]);
            hi1 += int'(bus.gate_hi[1]);
            lo2 += int'(bus.gate_lo[2]);
            if (!bus.gate_hi[0] && !bus.gate_lo[0]) begin
                bz0 += 1;
                cur += 1;
                if (cur > bzrun) bzrun = cur;
            end else begin
                cur = 0;
            end
            @(negedge clk);
            len += 1;
        end while (!bus.valley && len < 3000);
    endtask

    task automatic set_mods(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        bus.mod_a = a;
        bus.mod_b = b;
        bus.mod_c = c;
    endtask

    logic [15:0] vec [3][3] = '{
        '{16'h4000, 16'hC000, 16'h8000},
        '{16'h0000, 16'hFFFF, 16'h2000},
        '{16'hFFFF, 16'h0001, 16'h7FFF}
    };

    initial begin
        int waited;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.mod_a = 16'h8000;
        bus.mod_b = 16'h8000;
        bus.mod_c = 16'h8000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset_carrier", bus.carrier, 0);
        chk("reset_valley", bus.valley, 0);
        chk("reset_gate_hi", bus.gate_hi, 0);
        chk("reset_gate_lo", bus.gate_lo, 0);

        set_mods(16'h8000, 16'h0000, 16'hFFFF);
        bus.en = 1'b1;
        @(negedge clk);
        chk("first_valley", bus.valley, 1);

        measure_period();
        chk("valley_spacing", len, PER);
        chk("carrier_peak", maxc, CMAX);

        measure_period();
        chk("valley_spacing2", len, PER);
        chk("hi_a_per_period", hi0, EXP_HI0);
        chk("both_off_a_per_period", bz0, EXP_BZ0);
        chk("dead_window_a", bzrun, EXP_BZRUN);
        chk("hi_b_zero_duty", hi1, 0);
        chk("lo_c_full_duty", lo2, EXP_LO2);

        // reset while phase-a high gate is driven
        waited = 0;
        while (bus.gate_hi[0] !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_gate_hi_a", int'(waited < 3000), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midpulse_reset_hi", bus.gate_hi, 0);
        chk("midpulse_reset_lo", bus.gate_lo, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            set_mods(vec[v][0], vec[v][1], vec[v][2]);
            repeat (2 * PER + 20) @(posedge clk);
        end

        // random enables, rare resets, fresh samples every cycle
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            bus.mod_a = 16'($urandom);
            bus.mod_b = 16'($urandom);
            bus.mod_c = 16'($urandom);
            bus.en    = ($urandom_range(0, 49) != 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("disabled_gates", {bus.gate_hi, bus.gate_lo}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
